// File: rtl/scoreboard_regfile.sv
// Register file with a per-register scoreboard bit marking in-flight producers.
// Two registered read ports with write-first bypass and post-edge busy flags.
module scoreboard_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic              Write,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveRegister,
    output logic [ADDR_W:0]   BusyCount
);
    localparam int DEPTH  = 2**ADDR_W;
    localparam int NUM_RD = 2;

    logic [DEPTH-1:0][DATA_W-1:0]  rf;
    logic [DEPTH-1:0]              sb, sb_nxt;
    logic [ADDR_W:0]               cnt_nxt;
    logic                          wr_en, rsv_en;
    logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
    logic [NUM_RD-1:0][DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]             busy;

    // Index 0 is hardwired when ZERO_REG is set, so its traffic is dropped here.
    assign wr_en  = Write   && !((ZERO_REG != 0) && (WriteRegister   == '0));
    assign rsv_en = Reserve && !((ZERO_REG != 0) && (ReserveRegister == '0));

    // Reserve is applied after the write clear so a same-index pair ends busy.
    always_comb begin
        sb_nxt = sb;
        if (wr_en)  sb_nxt[WriteRegister]   = 1'b0;
        if (rsv_en) sb_nxt[ReserveRegister] = 1'b1;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(sb_nxt[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf        <= '0;
            sb        <= '0;
            BusyCount <= '0;
        end else begin
            if (wr_en) rf[WriteRegister] <= WriteData;
            sb        <= sb_nxt;
            BusyCount <= cnt_nxt;
        end
    end

    assign raddr = {ReadRegister2, ReadRegister1};

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        scoreboard_regfile_rdport #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .clk    (clk),
            .reset_n(reset_n),
            .raddr  (raddr[g]),
            .rf     (rf),
            .sb_nxt (sb_nxt),
            .wr_en  (wr_en),
            .waddr  (WriteRegister),
            .wdata  (WriteData),
            .rdata  (rdata[g]),
            .busy   (busy[g])
        );
    end

    assign ReadData1 = rdata[0];
    assign ReadData2 = rdata[1];
    assign Busy1     = busy[0];
    assign Busy2     = busy[1];
endmodule

// One registered read port: write-first bypass, busy from the post-edge scoreboard.
module scoreboard_regfile_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [ADDR_W-1:0]                 raddr,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]  rf,
    input  logic [2**ADDR_W-1:0]              sb_nxt,
    input  logic                              wr_en,
    input  logic [ADDR_W-1:0]                 waddr,
    input  logic [DATA_W-1:0]                 wdata,
    output logic [DATA_W-1:0]                 rdata,
    output logic                              busy
);
    logic [DATA_W-1:0] rdata_nxt;
    logic              busy_nxt;
    logic              is_zero;

    assign is_zero = (ZERO_REG != 0) && (raddr == '0);

    always_comb begin
        rdata_nxt = rf[raddr];
        busy_nxt  = sb_nxt[raddr];
        if (wr_en && (waddr == raddr)) rdata_nxt = wdata;
        if (is_zero) begin
            rdata_nxt = '0;
            busy_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
            busy  <= 1'b0;
        end else begin
            rdata <= rdata_nxt;
            busy  <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_scoreboard_regfile.sv
// Scoreboard bench: the driver pushes expected post-edge outputs from an array
// model of the register file; a negedge monitor pops and compares.
module tb_scoreboard_regfile;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2**AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] ReadRegister1 = '0, ReadRegister2 = '0;
    logic [DW-1:0] ReadData1, ReadData2;
    logic          Busy1, Busy2;
    logic          Write = 1'b0;
    logic [AW-1:0] WriteRegister = '0;
    logic [DW-1:0] WriteData = '0;
    logic          Reserve = 1'b0;
    logic [AW-1:0] ReserveRegister = '0;
    logic [AW:0]   BusyCount;

    scoreboard_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ReadRegister1  (ReadRegister1),
        .ReadRegister2  (ReadRegister2),
        .ReadData1      (ReadData1),
        .ReadData2      (ReadData2),
        .Busy1          (Busy1),
        .Busy2          (Busy2),
        .Write          (Write),
        .WriteRegister  (WriteRegister),
        .WriteData      (WriteData),
        .Reserve        (Reserve),
        .ReserveRegister(ReserveRegister),
        .BusyCount      (BusyCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rd1, rd2;
        logic        b1, b2;
        logic [5:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_rf[DEPTH];
    bit          m_sb[DEPTH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_clear();
        foreach (m_rf[i]) begin
            m_rf[i] = '0;
            m_sb[i] = 1'b0;
        end
    endtask

    // Register 0 is a constant zero; everything else is plain read-after-update.
    task automatic step(input string tag, input bit w, input int wa, input logic [31:0] wd,
                        input bit r, input int ra, input int ra1, input int ra2);
        exp_t e;
        int   c;
        @(negedge clk);
        Write = w; WriteRegister = AW'(wa); WriteData = wd;
        Reserve = r; ReserveRegister = AW'(ra);
        ReadRegister1 = AW'(ra1); ReadRegister2 = AW'(ra2);
        @(posedge clk);
        if (w && wa != 0) begin
            m_rf[wa] = wd;
            m_sb[wa] = 1'b0;
        end
        if (r && ra != 0) m_sb[ra] = 1'b1;
        c = 0;
        foreach (m_sb[i]) c += int'(m_sb[i]);
        e.tag = tag;
        e.rd1 = (ra1 == 0) ? 32'h0 : m_rf[ra1];
        e.rd2 = (ra2 == 0) ? 32'h0 : m_rf[ra2];
        e.b1  = (ra1 == 0) ? 1'b0 : m_sb[ra1];
        e.b2  = (ra2 == 0) ? 1'b0 : m_sb[ra2];
        e.cnt = 6'(c);
        exp_q.push_back(e);
        #1;
        Write = 1'b0;
        Reserve = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".rd1"}, 64'(ReadData1), 64'h0);
        chk({tag, ".rd2"}, 64'(ReadData2), 64'h0);
        chk({tag, ".b1"},  64'(Busy1), 64'h0);
        chk({tag, ".b2"},  64'(Busy2), 64'h0);
        chk({tag, ".cnt"}, 64'(BusyCount), 64'h0);
    endtask

    // Reset lands between edges with a write and reserve pending; both must be lost.
    task automatic mid_reset(input string tag);
        @(negedge clk);
        #1;
        Write = 1'b1; WriteRegister = AW'(1); WriteData = 32'hA5A5_A5A5;
        Reserve = 1'b1; ReserveRegister = AW'(2);
        reset_n = 1'b0;
        #1;
        chk_outputs_zero({tag, ".async"});
        @(posedge clk);
        #1;
        chk_outputs_zero({tag, ".held"});
        @(negedge clk);
        reset_n = 1'b1;
        Write = 1'b0;
        Reserve = 1'b0;
        model_clear();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".rd1"}, 64'(ReadData1), 64'(e.rd1));
            chk({e.tag, ".rd2"}, 64'(ReadData2), 64'(e.rd2));
            chk({e.tag, ".b1"},  64'(Busy1), 64'(e.b1));
            chk({e.tag, ".b2"},  64'(Busy2), 64'(e.b2));
            chk({e.tag, ".cnt"}, 64'(BusyCount), 64'(e.cnt));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        #2;
        chk_outputs_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        step("wr_r5",      1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        step("rd_r5",      0, 0, 32'h0,        0, 0, 5, 0);
        step("bypass_r7",  1, 7, 32'h0000_1234, 0, 0, 0, 7);
        step("rsv_r3",     0, 0, 32'h0,        1, 3, 3, 0);
        step("wr_r3",      1, 3, 32'h55,       0, 0, 3, 3);
        step("rd_r3",      0, 0, 32'h0,        0, 0, 3, 0);
        step("wr_rsv_r9",  1, 9, 32'hCAFE_0009, 1, 9, 9, 9);
        step("zero_r0",    1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        step("rsv_set_r9", 0, 0, 32'h0,        1, 9, 9, 0);
        step("wr_clear_r5",1, 5, 32'h1111_2222, 0, 0, 5, 9);

        for (int n = 0; n < 400; n++) begin
            int wa, ra, ra1, ra2;
            bit w, r;
            wa  = int'($urandom_range(0, DEPTH-1));
            ra  = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, DEPTH-1));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, DEPTH-1));
            ra2 = ($urandom_range(0, 3) == 0) ? ra1 : int'($urandom_range(0, DEPTH-1));
            w   = bit'($urandom_range(0, 1));
            r   = bit'($urandom_range(0, 1));
            step("rand", w, wa, $urandom, r, ra, ra1, ra2);
        end

        mid_reset("reset_clear");
        for (int i = 1; i <= 4; i++)
            step("wr_r1_4", 1, i, 32'h100 + 32'(i), 0, 0, i, 0);
        for (int i = 1; i <= 4; i++)
            step("rsv_r1_4", 0, 0, 32'h0, 1, i, i, 1);
        @(negedge clk);
        #1;
        chk("busycount_4", 64'(BusyCount), 64'd4);
        mid_reset("reset_mid");
        step("post_rst_a", 0, 0, 32'h0, 0, 0, 1, 2);
        step("post_rst_b", 0, 0, 32'h0, 0, 0, 3, 4);

        @(negedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
